// File: rtl/ttl74x_pkg.sv
// Package: ttl74x_pkg
// Definitions shared by the TTL74x461 up counter and its down-counting counterpart.
// Contents: the 2-bit instruction codes and the helper function is_zero().
package ttl74x_pkg;

   localparam int unsigned INSTR_W   = 2;
   localparam int unsigned MAX_WIDTH = 64;

   localparam logic [INSTR_W-1:0] INSTR_CLEAR = 2'b00;
   localparam logic [INSTR_W-1:0] INSTR_LOAD  = 2'b01;
   localparam logic [INSTR_W-1:0] INSTR_HOLD  = 2'b10;
   localparam logic [INSTR_W-1:0] INSTR_COUNT = 2'b11;

   // Callers zero-extend their count to MAX_WIDTH, so one function serves every stage width.
   function automatic logic is_zero(input logic [MAX_WIDTH-1:0] value);
      return (value == '0);
   endfunction

endpackage

// File: rtl/ttl74x_down_counter_if.sv
// Interface: ttl74x_down_counter_if
// Groups the instruction/data inputs and the count/borrow outputs of one counter stage.
//   I     instruction (00 clear, 01 load, 10 hold, 11 count down)
//   D     parallel load data
//   BI_n  borrow in, active low
//   OE_n  output enable, active low
//   Q     gated count
//   BO_n  borrow out, active low, combinational lookahead
//   TC    registered one-cycle terminal-count pulse
// Modports: master drives the controls, slave is the counter stage.
interface ttl74x_down_counter_if #(
   parameter int unsigned WIDTH = 8
);
   import ttl74x_pkg::*;

   logic [INSTR_W-1:0] I;
   logic [WIDTH-1:0]   D;
   logic               BI_n;
   logic               OE_n;
   logic [WIDTH-1:0]   Q;
   logic               BO_n;
   logic               TC;

   modport master (output I, D, BI_n, OE_n, input Q, BO_n, TC);
   modport slave  (input I, D, BI_n, OE_n, output Q, BO_n, TC);

endinterface

// File: rtl/ttl74x_preset_reg.sv
// Module: ttl74x_preset_reg
// Holds the reload value used when the down counter wraps in auto-reload builds.
// Built only when TTL74X_DOWN_COUNTER_AUTO_RELOAD_EN is defined.
//   clk       clock
//   rst_n     asynchronous active-low reset
//   load_en_i capture d_i on the next rising edge
//   d_i       value to capture
//   preset_o  stored preset
`ifdef TTL74X_DOWN_COUNTER_AUTO_RELOAD_EN
module ttl74x_preset_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] preset_o
);

   logic [WIDTH-1:0] preset_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         preset_q <= '0;
      end else if (load_en_i) begin
         preset_q <= d_i;
      end
   end

   assign preset_o = preset_q;

endmodule
`endif

// File: rtl/ttl74x_down_counter.sv
// Module: ttl74x_down_counter
// Presettable down counter with borrow-in/borrow-out for cascading, matching the 461 family
// instruction set. Configuration macro: TTL74X_DOWN_COUNTER_AUTO_RELOAD_EN (the wrap from 0
// reloads the last loaded value instead of all-ones).
//   CLK    rising-edge clock
//   CLR_n  asynchronous active-low clear
//   bus    slave side of ttl74x_down_counter_if (I, D, BI_n, OE_n in; Q, BO_n, TC out)
module ttl74x_down_counter
   import ttl74x_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  CLR_n,
   ttl74x_down_counter_if.slave  bus
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             count_zero;
   logic             dec_en;
   logic [WIDTH-1:0] wrap_val;

   assign count_zero = is_zero(MAX_WIDTH'(count_q));
   assign dec_en     = (bus.I == INSTR_COUNT) && !bus.BI_n;

`ifdef TTL74X_DOWN_COUNTER_AUTO_RELOAD_EN
   // Preset tracks every parallel load so the wrap reloads the last D.
   ttl74x_preset_reg #(
      .WIDTH (WIDTH)
   ) u_preset_reg (
      .clk       (CLK),
      .rst_n     (CLR_n),
      .load_en_i (bus.I == INSTR_LOAD),
      .d_i       (bus.D),
      .preset_o  (wrap_val)
   );
`else
   assign wrap_val = '1;
`endif

   // Instruction decode for the next count.
   always_comb begin
      count_d = count_q;
      case (bus.I)
         INSTR_CLEAR: count_d = '0;
         INSTR_LOAD:  count_d = bus.D;
         INSTR_HOLD:  count_d = count_q;
         INSTR_COUNT: begin
            if (!bus.BI_n) begin
               count_d = count_zero ? wrap_val : (count_q - WIDTH'(1));
            end
         end
         default:     count_d = count_q;
      endcase
   end

   // TC marks the cycle after a decrement out of zero.
   assign tc_d = dec_en && count_zero;

   always_ff @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   // Borrow lookahead lets the next stage decrement on the same edge.
   assign bus.BO_n = !(dec_en && count_zero);
   assign bus.Q    = bus.OE_n ? '0 : count_q;
   assign bus.TC   = tc_q;

endmodule

// File: tb/tb_ttl74x_down_counter.sv
module tb_ttl74x_down_counter;
   import ttl74x_pkg::*;

   localparam int unsigned W = 8;

   logic CLK;
   logic CLR_n;
   int   checks;
   int   errors;

   ttl74x_down_counter_if #(.WIDTH(W)) bus  ();
   ttl74x_down_counter_if #(.WIDTH(W)) c_lo ();
   ttl74x_down_counter_if #(.WIDTH(W)) c_hi ();

   ttl74x_down_counter #(.WIDTH(W)) u_dut (.CLK(CLK), .CLR_n(CLR_n), .bus(bus));
   ttl74x_down_counter #(.WIDTH(W)) u_lo  (.CLK(CLK), .CLR_n(CLR_n), .bus(c_lo));
   ttl74x_down_counter #(.WIDTH(W)) u_hi  (.CLK(CLK), .CLR_n(CLR_n), .bus(c_hi));

   // Cascade: hi stage shares controls, borrows from lo stage.
   assign c_hi.I    = c_lo.I;
   assign c_hi.D    = c_lo.D;
   assign c_hi.OE_n = c_lo.OE_n;
   assign c_hi.BI_n = c_lo.BO_n;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0]   i;
      logic [W-1:0] d;
      logic         bi_n;
      logic         oe_n;
      logic         exp_bo;
      logic [W-1:0] exp_q;
      logic         exp_tc;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] i, input logic [W-1:0] d, input logic bi_n, input logic oe_n);
      bus.I    = i;
      bus.D    = d;
      bus.BI_n = bi_n;
      bus.OE_n = oe_n;
   endtask

   initial begin
      logic [W-1:0] seq6 [9];
      checks = 0;
      errors = 0;

      // Vectors start from count 03 with TC low.
      vecs[0]  = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0};
      vecs[1]  = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0};
      vecs[2]  = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
`ifdef TTL74X_DOWN_COUNTER_AUTO_RELOAD_EN
      vecs[3]  = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 1'b1};
`else
      vecs[3]  = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1};
`endif
      vecs[4]  = '{2'b01, 8'h10, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0};
      vecs[5]  = '{2'b11, 8'h00, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0};
      vecs[6]  = '{2'b11, 8'h00, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0};
      vecs[7]  = '{2'b11, 8'h00, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0};
      vecs[8]  = '{2'b10, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0};
      vecs[9]  = '{2'b01, 8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0};
      vecs[10] = '{2'b10, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
      vecs[11] = '{2'b10, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0};
      vecs[12] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
      vecs[13] = '{2'b11, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
      vecs[14] = '{2'b01, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
`ifdef TTL74X_DOWN_COUNTER_AUTO_RELOAD_EN
      vecs[15] = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[16] = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
`else
      vecs[15] = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1};
      vecs[16] = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b0};
`endif

      // Reset state
      CLR_n = 1'b0;
      drive(2'b11, 8'h00, 1'b0, 1'b0);
      c_lo.I = 2'b10; c_lo.D = 8'h00; c_lo.BI_n = 1'b1; c_lo.OE_n = 1'b0;
      #2;
      check("reset_q", 16'(bus.Q), 16'h0000);
      check("reset_tc", 16'(bus.TC), 16'h0000);
      check("reset_bo_follows_bi", 16'(bus.BO_n), 16'h0000);
      @(negedge CLK);
      CLR_n = 1'b1;

      // Load 5A, then assert clear mid-count before any edge
      drive(2'b01, 8'h5A, 1'b0, 1'b0);
      @(posedge CLK); #1;
      check("load_5a", 16'(bus.Q), 16'h005A);
      @(negedge CLK);
      drive(2'b11, 8'h00, 1'b0, 1'b0);
      #2 CLR_n = 1'b0;
      #1;
      check("async_clr_q", 16'(bus.Q), 16'h0000);
      check("async_clr_tc", 16'(bus.TC), 16'h0000);
      @(negedge CLK);
      CLR_n = 1'b1;
      drive(2'b01, 8'h03, 1'b0, 1'b0);
      @(posedge CLK); #1;
      check("load_03", 16'(bus.Q), 16'h0003);

      // Directed vector table
      for (int k = 0; k < NVEC; k++) begin
         @(negedge CLK);
         drive(vecs[k].i, vecs[k].d, vecs[k].bi_n, vecs[k].oe_n);
         #1;
         check($sformatf("vec%0d_bo", k), 16'(bus.BO_n), 16'(vecs[k].exp_bo));
         @(posedge CLK); #1;
         check($sformatf("vec%0d_q", k), 16'(bus.Q), 16'(vecs[k].exp_q));
         check($sformatf("vec%0d_tc", k), 16'(bus.TC), 16'(vecs[k].exp_tc));
      end

      // Cascade: both stages loaded with 00, then count
      @(negedge CLK);
      c_lo.I = 2'b01; c_lo.D = 8'h00; c_lo.BI_n = 1'b0;
      @(posedge CLK); #1;
      check("casc_load", {c_hi.Q, c_lo.Q}, 16'h0000);
      @(negedge CLK);
      c_lo.I = 2'b11;
      #1;
      check("casc_hi_bo", 16'(c_hi.BO_n), 16'h0000);
      @(posedge CLK); #1;
`ifdef TTL74X_DOWN_COUNTER_AUTO_RELOAD_EN
      check("casc_step1", {c_hi.Q, c_lo.Q}, 16'h0000);
`else
      check("casc_step1", {c_hi.Q, c_lo.Q}, 16'hFFFF);
`endif
      check("casc_hi_tc", 16'(c_hi.TC), 16'h0001);
      @(posedge CLK); #1;
`ifdef TTL74X_DOWN_COUNTER_AUTO_RELOAD_EN
      check("casc_step2", {c_hi.Q, c_lo.Q}, 16'h0000);
`else
      check("casc_step2", {c_hi.Q, c_lo.Q}, 16'hFFFE);
`endif
      @(negedge CLK);
      c_lo.I = 2'b10;

`ifdef TTL74X_DOWN_COUNTER_AUTO_RELOAD_EN
      // Divide-by-3 with preset 02
      seq6[0] = 8'h01; seq6[1] = 8'h00; seq6[2] = 8'h02;
      seq6[3] = 8'h01; seq6[4] = 8'h00; seq6[5] = 8'h02;
      seq6[6] = 8'h01; seq6[7] = 8'h00; seq6[8] = 8'h02;
      @(negedge CLK);
      drive(2'b01, 8'h02, 1'b0, 1'b0);
      @(posedge CLK); #1;
      check("reload_load", 16'(bus.Q), 16'h0002);
      @(negedge CLK);
      drive(2'b11, 8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 9; k++) begin
         @(posedge CLK); #1;
         check($sformatf("reload_q%0d", k), 16'(bus.Q), 16'(seq6[k]));
         check($sformatf("reload_tc%0d", k), 16'(bus.TC), (seq6[k] == 8'h02) ? 16'h0001 : 16'h0000);
      end
`else
      seq6[0] = 8'h00;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
